// File: rtl/sdma_inst_queue_ctrl_pkg.sv
// Shared constants and state type for the SDMA instruction queue controller.
package sdma_inst_queue_ctrl_pkg;

  localparam int unsigned SDMA_INSTWIDTH = 32;
  localparam int unsigned SDMA_QDEPTH    = 4;

  typedef enum logic [1:0] {
    SQC_IDLE   = 2'd0,
    SQC_CONFIG = 2'd1,
    SQC_WORK   = 2'd2,
    SQC_ERROR  = 2'd3
  } sqc_state_e;

  // Dispatch is only possible from IDLE with work queued and a willing sub-channel.
  function automatic logic sqc_can_dispatch(input logic en, input logic empty,
                                            input logic ready);
    return en & ~empty & ready;
  endfunction

endpackage

// File: rtl/sdma_inst_fifo.sv
// Instruction queue storage: strict FIFO, DEPTH (power of 2) entries, synchronous flush.
module sdma_inst_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned INST_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [INST_W-1:0]        push_data_i,
  input  logic                     pop_i,
  output logic [INST_W-1:0]        head_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic [INST_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]     level_q;
  logic              do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  // Entry storage; contents are don't-care until written, so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/sdma_inst_queue_ctrl.sv
// SDMA instruction queue controller: buffers instructions, dispatches one job at a
// time to the sub-channel controller, and guards each job with a watchdog.
module sdma_inst_queue_ctrl
  import sdma_inst_queue_ctrl_pkg::*;
#(
  parameter int unsigned INST_W = SDMA_INSTWIDTH,
  parameter int unsigned DEPTH  = SDMA_QDEPTH,
  parameter int unsigned TMO_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_sqc_en,
  input  logic                   i_sqc_inst_vld,
  output logic                   o_sqc_inst_rdy,
  input  logic [INST_W-1:0]      i_sqc_inst,
  input  logic                   i_sqc_sscready,
  input  logic                   i_sqc_ssctransferdone,
  input  logic                   i_sqc_abort,
  input  logic [TMO_W-1:0]       i_sqc_tmo_limit,
  output logic                   o_sqc_sscen,
  output logic [INST_W-1:0]      o_sqc_exec_inst,
  output logic [$clog2(DEPTH):0] o_sqc_level,
  output logic                   o_sqc_idle,
  output logic                   o_sqc_timeout,
  output logic [15:0]            o_sqc_donecnt,
  output logic [1:0]             o_sqc_state
);

  localparam logic [TMO_W-1:0] TMO_ONE = TMO_W'(1);

  sqc_state_e        state_q, state_d;
  logic [INST_W-1:0] exec_q, exec_d;
  logic              sscen_q, sscen_d;
  logic              timeout_q, timeout_d;
  logic [15:0]       donecnt_q, donecnt_d;
  logic [TMO_W-1:0]  wdog_q, wdog_d;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [INST_W-1:0] fifo_head;
  logic [$clog2(DEPTH):0] fifo_level;
  logic              wdog_expired;

  // Ready is taken from registered occupancy only, so a pop never frees a slot early.
  assign o_sqc_inst_rdy = ~fifo_full;
  assign fifo_push      = i_sqc_inst_vld & ~fifo_full & ~i_sqc_abort;

  sdma_inst_fifo #(
    .DEPTH  (DEPTH),
    .INST_W (INST_W)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (i_sqc_abort),
    .push_i      (fifo_push),
    .push_data_i (i_sqc_inst),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .level_o     (fifo_level),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign wdog_expired = (i_sqc_tmo_limit != '0) && (wdog_q == (i_sqc_tmo_limit - TMO_ONE));

  // Job sequencing, watchdog and completion accounting; abort overrides everything.
  always_comb begin
    state_d   = state_q;
    exec_d    = exec_q;
    sscen_d   = sscen_q;
    timeout_d = timeout_q;
    donecnt_d = donecnt_q;
    wdog_d    = wdog_q;
    fifo_pop  = 1'b0;

    case (state_q)
      SQC_IDLE: begin
        if (sqc_can_dispatch(i_sqc_en, fifo_empty, i_sqc_sscready)) begin
          state_d  = SQC_CONFIG;
          fifo_pop = 1'b1;
          exec_d   = fifo_head;
          sscen_d  = 1'b1;
          wdog_d   = '0;
        end
      end
      SQC_CONFIG: begin
        state_d = SQC_WORK;
        wdog_d  = '0;
      end
      SQC_WORK: begin
        if (i_sqc_ssctransferdone) begin
          state_d   = SQC_IDLE;
          exec_d    = '0;
          sscen_d   = 1'b0;
          donecnt_d = donecnt_q + 16'd1;
          wdog_d    = '0;
        end else if (wdog_expired) begin
          state_d   = SQC_ERROR;
          sscen_d   = 1'b0;
          timeout_d = 1'b1;
        end else begin
          wdog_d = wdog_q + TMO_ONE;
        end
      end
      SQC_ERROR: begin
        state_d = SQC_ERROR;
      end
      default: begin
        state_d = SQC_IDLE;
      end
    endcase

    if (i_sqc_abort) begin
      state_d   = SQC_IDLE;
      exec_d    = '0;
      sscen_d   = 1'b0;
      timeout_d = 1'b0;
      wdog_d    = '0;
      donecnt_d = donecnt_q;
      fifo_pop  = 1'b0;
    end
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SQC_IDLE;
      exec_q    <= '0;
      sscen_q   <= 1'b0;
      timeout_q <= 1'b0;
      donecnt_q <= '0;
      wdog_q    <= '0;
    end else begin
      state_q   <= state_d;
      exec_q    <= exec_d;
      sscen_q   <= sscen_d;
      timeout_q <= timeout_d;
      donecnt_q <= donecnt_d;
      wdog_q    <= wdog_d;
    end
  end

  assign o_sqc_sscen     = sscen_q;
  assign o_sqc_exec_inst = exec_q;
  assign o_sqc_level     = fifo_level;
  assign o_sqc_idle      = (state_q == SQC_IDLE) && fifo_empty;
  assign o_sqc_timeout   = timeout_q;
  assign o_sqc_donecnt   = donecnt_q;
  assign o_sqc_state     = state_q;

endmodule

// File: tb/tb_sdma_inst_queue_ctrl.sv
// Self-checking bench for sdma_inst_queue_ctrl: directed scenarios plus randomized
// traffic compared against a queue-based behavioural model.
module tb_sdma_inst_queue_ctrl;

  localparam int DEPTH  = 4;
  localparam int INST_W = 32;
  localparam int TMO_W  = 16;

  logic              clk, rst_n;
  logic              en, vld, rdy, ready, done, abort;
  logic [INST_W-1:0] inst, exec_inst;
  logic [TMO_W-1:0]  limit;
  logic              sscen, idle, timeout;
  logic [2:0]        level;
  logic [15:0]       donecnt;
  logic [1:0]        state;

  int n_checks = 0;
  int n_pass   = 0;

  sdma_inst_queue_ctrl #(
    .INST_W (INST_W),
    .DEPTH  (DEPTH),
    .TMO_W  (TMO_W)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .i_sqc_en              (en),
    .i_sqc_inst_vld        (vld),
    .o_sqc_inst_rdy        (rdy),
    .i_sqc_inst            (inst),
    .i_sqc_sscready        (ready),
    .i_sqc_ssctransferdone (done),
    .i_sqc_abort           (abort),
    .i_sqc_tmo_limit       (limit),
    .o_sqc_sscen           (sscen),
    .o_sqc_exec_inst       (exec_inst),
    .o_sqc_level           (level),
    .o_sqc_idle            (idle),
    .o_sqc_timeout         (timeout),
    .o_sqc_donecnt         (donecnt),
    .o_sqc_state           (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // job: 0 idle, 1 config, 2 work, 3 error; work_done counts completed WORK cycles
  logic [INST_W-1:0] mq[$];
  int                m_job;
  logic [INST_W-1:0] m_exec;
  logic              m_ssc, m_tmo;
  logic [15:0]       m_done;
  int                m_work_done;

  task automatic model_reset();
    mq.delete();
    m_job = 0; m_exec = '0; m_ssc = 0; m_tmo = 0; m_done = '0; m_work_done = 0;
  endtask

  task automatic model_step();
    bit accept;
    accept = vld && (mq.size() != DEPTH);
    if (abort) begin
      mq.delete();
      m_job = 0; m_exec = '0; m_ssc = 0; m_tmo = 0; m_work_done = 0;
      return;
    end
    case (m_job)
      0: if (en && ready && mq.size() > 0) begin
           m_exec = mq.pop_front(); m_ssc = 1; m_job = 1; m_work_done = 0;
         end
      1: m_job = 2;
      2: if (done) begin
           m_job = 0; m_exec = '0; m_ssc = 0; m_done = m_done + 16'd1;
         end else if (limit != 0 && m_work_done + 1 == int'(limit)) begin
           m_job = 3; m_ssc = 0; m_tmo = 1;
         end else begin
           m_work_done++;
         end
      default: ;
    endcase
    if (accept) mq.push_back(inst);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_inputs();
    en = 0; vld = 0; ready = 0; done = 0; abort = 0; limit = '0; inst = '0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (state !== 2'd0)  $display("FAIL rst_state: got %0d expected 0", state); else n_pass++;
    n_checks++; if (level !== 3'd0)  $display("FAIL rst_level: got %0d expected 0", level); else n_pass++;
    n_checks++; if (rdy !== 1'b1)    $display("FAIL rst_rdy: got %b expected 1", rdy); else n_pass++;
    n_checks++; if (sscen !== 1'b0)  $display("FAIL rst_sscen: got %b expected 0", sscen); else n_pass++;
    n_checks++; if (exec_inst !== '0) $display("FAIL rst_exec: got %0h expected 0", exec_inst); else n_pass++;
    n_checks++; if (timeout !== 1'b0) $display("FAIL rst_timeout: got %b expected 0", timeout); else n_pass++;
    n_checks++; if (donecnt !== 16'd0) $display("FAIL rst_donecnt: got %0d expected 0", donecnt); else n_pass++;
    n_checks++; if (idle !== 1'b1)   $display("FAIL rst_idle: got %b expected 1", idle); else n_pass++;
    @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  task automatic test_dispatch();
    logic [INST_W-1:0] a, b, c;
    a = 32'hA000_0001; b = 32'hB000_0002; c = 32'hC000_0003;
    en = 1; ready = 1; limit = '0;
    vld = 1; inst = a; tick();
    inst = b; tick();
    n_checks++; if (state !== 2'd1)  $display("FAIL disp_state_cfg: got %0d expected 1", state); else n_pass++;
    n_checks++; if (exec_inst !== a) $display("FAIL disp_exec_a: got %0h expected %0h", exec_inst, a); else n_pass++;
    n_checks++; if (sscen !== 1'b1)  $display("FAIL disp_sscen: got %b expected 1", sscen); else n_pass++;
    n_checks++; if (level !== 3'd1)  $display("FAIL disp_level1: got %0d expected 1", level); else n_pass++;
    inst = c; tick();
    vld = 0;
    n_checks++; if (state !== 2'd2)  $display("FAIL disp_state_work: got %0d expected 2", state); else n_pass++;
    n_checks++; if (level !== 3'd2)  $display("FAIL disp_level2: got %0d expected 2", level); else n_pass++;
    repeat (3) tick();
    n_checks++; if (exec_inst !== a || level !== 3'd2)
      $display("FAIL disp_b_waits: got exec %0h level %0d expected %0h 2", exec_inst, level, a); else n_pass++;
    done = 1; tick(); done = 0;
    n_checks++; if (state !== 2'd0 || exec_inst !== '0 || sscen !== 1'b0)
      $display("FAIL disp_done_a: got state %0d exec %0h sscen %b expected 0 0 0", state, exec_inst, sscen); else n_pass++;
    n_checks++; if (donecnt !== 16'd1) $display("FAIL disp_donecnt1: got %0d expected 1", donecnt); else n_pass++;
    tick();
    n_checks++; if (exec_inst !== b) $display("FAIL disp_exec_b: got %0h expected %0h", exec_inst, b); else n_pass++;
    tick(); done = 1; tick(); done = 0;
    tick();
    n_checks++; if (exec_inst !== c) $display("FAIL disp_exec_c: got %0h expected %0h", exec_inst, c); else n_pass++;
    tick(); done = 1; tick(); done = 0;
    n_checks++; if (idle !== 1'b1 || donecnt !== 16'd3)
      $display("FAIL disp_drained: got idle %b donecnt %0d expected 1 3", idle, donecnt); else n_pass++;
    clear_inputs();
  endtask

  task automatic test_backpressure();
    en = 0; ready = 1; vld = 1;
    for (int i = 0; i < 4; i++) begin
      inst = 32'h1000 + i; tick();
    end
    n_checks++; if (level !== 3'd4 || rdy !== 1'b0)
      $display("FAIL bp_full: got level %0d rdy %b expected 4 0", level, rdy); else n_pass++;
    inst = 32'h5555; tick();
    n_checks++; if (level !== 3'd4) $display("FAIL bp_held: got level %0d expected 4", level); else n_pass++;
    en = 1; tick();
    n_checks++; if (level !== 3'd3 || rdy !== 1'b1 || exec_inst !== 32'h1000)
      $display("FAIL bp_pop: got level %0d rdy %b exec %0h expected 3 1 1000", level, rdy, exec_inst); else n_pass++;
    tick(); vld = 0;
    n_checks++; if (level !== 3'd4 || rdy !== 1'b0)
      $display("FAIL bp_fifth: got level %0d rdy %b expected 4 0", level, rdy); else n_pass++;
    n_checks++; if (mq[3] !== 32'h5555) $display("FAIL bp_model_tail: got %0h expected 5555", mq[3]); else n_pass++;
    abort = 1; tick(); abort = 0;
    n_checks++; if (level !== 3'd0 || state !== 2'd0 || exec_inst !== '0 || donecnt !== m_done)
      $display("FAIL bp_abort: got level %0d state %0d exec %0h donecnt %0d expected 0 0 0 %0d",
               level, state, exec_inst, donecnt, m_done); else n_pass++;
    clear_inputs();
  endtask

  task automatic test_watchdog();
    int wc;
    en = 1; ready = 1; limit = 16'd10;
    vld = 1; inst = 32'hDEAD_0010; tick(); vld = 0;
    tick(); tick();
    wc = 0;
    while (state === 2'd2 && wc < 40) begin
      tick(); wc++;
    end
    n_checks++; if (wc !== 10) $display("FAIL wd_cycles: got %0d expected 10", wc); else n_pass++;
    n_checks++; if (state !== 2'd3 || timeout !== 1'b1 || sscen !== 1'b0)
      $display("FAIL wd_error: got state %0d timeout %b sscen %b expected 3 1 0", state, timeout, sscen); else n_pass++;
    vld = 1; inst = 32'h0BAD; tick(); vld = 0; tick();
    n_checks++; if (level !== 3'd1 || state !== 2'd3)
      $display("FAIL wd_err_enq: got level %0d state %0d expected 1 3", level, state); else n_pass++;
    abort = 1; vld = 1; inst = 32'h0777; tick(); abort = 0; vld = 0;
    n_checks++; if (state !== 2'd0 || level !== 3'd0 || timeout !== 1'b0 || sscen !== 1'b0 || exec_inst !== '0)
      $display("FAIL wd_abort: got state %0d level %0d timeout %b sscen %b exec %0h expected 0 0 0 0 0",
               state, level, timeout, sscen, exec_inst); else n_pass++;
    clear_inputs();
  endtask

  task automatic test_done_expiry();
    logic [15:0] d0;
    d0 = m_done;
    en = 1; ready = 1; limit = 16'd5;
    vld = 1; inst = 32'hFEED_0005; tick(); vld = 0;
    tick(); tick();
    repeat (4) tick();
    n_checks++; if (state !== 2'd2) $display("FAIL de_still_work: got %0d expected 2", state); else n_pass++;
    done = 1; tick(); done = 0;
    n_checks++; if (state !== 2'd0 || timeout !== 1'b0 || donecnt !== d0 + 16'd1)
      $display("FAIL de_done_wins: got state %0d timeout %b donecnt %0d expected 0 0 %0d",
               state, timeout, donecnt, d0 + 16'd1); else n_pass++;
    clear_inputs();
  endtask

  task automatic test_push_pop_same();
    logic [INST_W-1:0] x [4];
    for (int i = 0; i < 4; i++) x[i] = 32'h7700_0000 + 32'(i * 17);
    en = 0; ready = 1; vld = 1;
    for (int i = 0; i < 3; i++) begin
      inst = x[i]; tick();
    end
    inst = x[3]; en = 1; tick(); vld = 0;
    n_checks++; if (level !== 3'd3 || exec_inst !== x[0] || state !== 2'd1)
      $display("FAIL pp_same: got level %0d exec %0h state %0d expected 3 %0h 1", level, exec_inst, state, x[0]); else n_pass++;
    for (int k = 1; k < 4; k++) begin
      tick(); done = 1; tick(); done = 0; tick();
      n_checks++; if (exec_inst !== x[k])
        $display("FAIL pp_order%0d: got %0h expected %0h", k, exec_inst, x[k]); else n_pass++;
    end
    tick(); done = 1; tick(); done = 0;
    n_checks++; if (idle !== 1'b1) $display("FAIL pp_drained: got idle %b expected 1", idle); else n_pass++;
    clear_inputs();
  endtask

  task automatic test_random();
    logic [TMO_W-1:0] lims [4];
    lims[0] = 16'd0; lims[1] = 16'd3; lims[2] = 16'd6; lims[3] = 16'd12;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      en    = ($urandom_range(0, 3) != 0);
      ready = ($urandom_range(0, 3) != 0);
      vld   = ($urandom_range(0, 1) != 0);
      inst  = $urandom;
      done  = ($urandom_range(0, 4) == 0);
      abort = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 30) == 0) limit = lims[$urandom_range(0, 3)];
      tick();
      n_checks++; if (state !== 2'(m_job)) $display("FAIL rnd_state @%0d: got %0d expected %0d", cyc, state, m_job); else n_pass++;
      n_checks++; if (level !== 3'(mq.size())) $display("FAIL rnd_level @%0d: got %0d expected %0d", cyc, level, mq.size()); else n_pass++;
      n_checks++; if (rdy !== (mq.size() != DEPTH)) $display("FAIL rnd_rdy @%0d: got %b expected %b", cyc, rdy, mq.size() != DEPTH); else n_pass++;
      n_checks++; if (exec_inst !== m_exec) $display("FAIL rnd_exec @%0d: got %0h expected %0h", cyc, exec_inst, m_exec); else n_pass++;
      n_checks++; if (sscen !== m_ssc) $display("FAIL rnd_sscen @%0d: got %b expected %b", cyc, sscen, m_ssc); else n_pass++;
      n_checks++; if (timeout !== m_tmo) $display("FAIL rnd_timeout @%0d: got %b expected %b", cyc, timeout, m_tmo); else n_pass++;
      n_checks++; if (donecnt !== m_done) $display("FAIL rnd_donecnt @%0d: got %0d expected %0d", cyc, donecnt, m_done); else n_pass++;
      n_checks++; if (idle !== (m_job == 0 && mq.size() == 0))
        $display("FAIL rnd_idle @%0d: got %b expected %b", cyc, idle, m_job == 0 && mq.size() == 0); else n_pass++;
    end
    clear_inputs();
    abort = 1; tick(); abort = 0;
  endtask

  task automatic test_reset_midjob();
    en = 0; ready = 1; vld = 1;
    for (int i = 0; i < 3; i++) begin
      inst = 32'h4400 + i; tick();
    end
    vld = 0; en = 1; tick(); tick();
    n_checks++; if (state !== 2'd2 || level !== 3'd2)
      $display("FAIL rm_setup: got state %0d level %0d expected 2 2", state, level); else n_pass++;
    clear_inputs();
    #2 rst_n = 0;
    #1;
    n_checks++; if (state !== 2'd0 || level !== 3'd0 || exec_inst !== '0 || sscen !== 1'b0)
      $display("FAIL rm_async: got state %0d level %0d exec %0h sscen %b expected 0 0 0 0",
               state, level, exec_inst, sscen); else n_pass++;
    n_checks++; if (donecnt !== 16'd0 || timeout !== 1'b0 || rdy !== 1'b1 || idle !== 1'b1)
      $display("FAIL rm_async2: got donecnt %0d timeout %b rdy %b idle %b expected 0 0 1 1",
               donecnt, timeout, rdy, idle); else n_pass++;
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0;
    clear_inputs();
    model_reset();
    test_reset();
    test_dispatch();
    test_backpressure();
    test_watchdog();
    test_done_expiry();
    test_push_pop_same();
    test_random();
    test_reset_midjob();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
